// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the load-executor state enum.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_REQ,
        LD_WAIT,
        LD_WB,
        LD_ERR
    } ld_state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/ins_exec_rv32i_load_if.sv
// Data-memory read port: request/grant, then a separate valid beat.
interface ins_exec_rv32i_load_if;

    logic        mem_r_req;
    logic [31:0] mem_r_addr;
    logic        mem_r_gnt;
    logic        mem_r_valid;
    logic [31:0] mem_r_val;

    modport master (
        output mem_r_req,
        output mem_r_addr,
        input  mem_r_gnt,
        input  mem_r_valid,
        input  mem_r_val
    );

    modport slave (
        input  mem_r_req,
        input  mem_r_addr,
        output mem_r_gnt,
        output mem_r_valid,
        output mem_r_val
    );

endinterface

// File: rtl/load_extend.sv
// Width select and sign/zero extension of a raw load word.
module load_extend
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o
);

    always_comb begin
        ext_o = raw_i;
        unique case (1'b1)
            (funct3_i == F3_B):  ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
            (funct3_i == F3_H):  ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
            (funct3_i == F3_BU): ext_o = {24'd0, raw_i[7:0]};
            (funct3_i == F3_HU): ext_o = {16'd0, raw_i[15:0]};
            default:             ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/ins_exec_rv32i_load.sv
// Multi-cycle RV32I load executor: one memory read per load,
// extended result written back as a single-cycle pulse.
module ins_exec_rv32i_load #(
    parameter logic [6:0] OPC_LOAD = 7'b0000011
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          op,
    input  logic [6:0]                    ins_dec_op,
    input  logic [2:0]                    ins_dec_funct3,
    input  logic [4:0]                    ins_dec_rd,
    input  logic [31:0]                   reg_rs1_val,
    input  logic [31:0]                   imm_ext_ext,
    input  logic                          flush,
    ins_exec_rv32i_load_if.master         mem,
    output logic                          busy,
    output logic                          reg_w_op,
    output logic [4:0]                    reg_w_rd,
    output logic [31:0]                   reg_w_val,
    output logic                          done,
    output logic                          exc_illegal
);

    import rv32i_pkg::*;

    ld_state_e   state_q;
    logic [31:0] addr_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [31:0] val_q;
    logic        kill_q;
    logic [31:0] ext_w;

    load_extend u_ext (
        .funct3_i (f3_q),
        .raw_i    (mem.mem_r_val),
        .ext_o    (ext_w)
    );

    // Once granted, the response must be drained even if killed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            val_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            unique case (state_q)
                LD_IDLE: begin
                    if (op && ins_dec_op == OPC_LOAD && !flush) begin
                        addr_q  <= reg_rs1_val + imm_ext_ext;
                        rd_q    <= ins_dec_rd;
                        f3_q    <= ins_dec_funct3;
                        kill_q  <= 1'b0;
                        state_q <= f3_legal(ins_dec_funct3) ? LD_REQ
                                                            : LD_ERR;
                    end
                end
                LD_REQ: begin
                    if (mem.mem_r_gnt) begin
                        kill_q  <= flush;
                        state_q <= LD_WAIT;
                    end else if (flush) begin
                        state_q <= LD_IDLE;
                    end
                end
                LD_WAIT: begin
                    if (mem.mem_r_valid) begin
                        val_q   <= ext_w;
                        state_q <= (kill_q || flush) ? LD_IDLE : LD_WB;
                    end else if (flush) begin
                        kill_q  <= 1'b1;
                    end
                end
                LD_WB:   state_q <= LD_IDLE;
                LD_ERR:  state_q <= LD_IDLE;
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    assign mem.mem_r_req  = (state_q == LD_REQ);
    assign mem.mem_r_addr = (state_q == LD_REQ) ? addr_q : '0;

    assign busy        = (state_q != LD_IDLE);
    assign done        = (state_q == LD_WB) || (state_q == LD_ERR);
    assign exc_illegal = (state_q == LD_ERR);
    assign reg_w_op    = (state_q == LD_WB) && (rd_q != 5'd0);
    assign reg_w_rd    = reg_w_op ? rd_q : '0;
    assign reg_w_val   = reg_w_op ? val_q : '0;

endmodule

// File: tb/tb_ins_exec_rv32i_load.sv
// Bench for the RV32I load executor: directed table, reset, random.
module tb_ins_exec_rv32i_load;
  import rv32i_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        op;
  logic [6:0]  ins_dec_op;
  logic [2:0]  ins_dec_funct3;
  logic [4:0]  ins_dec_rd;
  logic [31:0] reg_rs1_val;
  logic [31:0] imm_ext_ext;
  logic        flush;
  logic        busy;
  logic        reg_w_op;
  logic [4:0]  reg_w_rd;
  logic [31:0] reg_w_val;
  logic        done;
  logic        exc_illegal;

  ins_exec_rv32i_load_if mif ();

  ins_exec_rv32i_load dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .op             (op),
    .ins_dec_op     (ins_dec_op),
    .ins_dec_funct3 (ins_dec_funct3),
    .ins_dec_rd     (ins_dec_rd),
    .reg_rs1_val    (reg_rs1_val),
    .imm_ext_ext    (imm_ext_ext),
    .flush          (flush),
    .mem            (mif.master),
    .busy           (busy),
    .reg_w_op       (reg_w_op),
    .reg_w_rd       (reg_w_rd),
    .reg_w_val      (reg_w_val),
    .done           (done),
    .exc_illegal    (exc_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic        exc;
    logic        wop;
    logic [4:0]  wrd;
    logic [31:0] wval;
  } out_t;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] word;
    int          g;
    int          v;
    int          f;
    logic [31:0] ea;
    logic [31:0] ev;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[13];

  function automatic out_t act();
    out_t a;
    a.req  = mif.mem_r_req;
    a.addr = mif.mem_r_addr;
    a.busy = busy;
    a.done = done;
    a.exc  = exc_illegal;
    a.wop  = reg_w_op;
    a.wrd  = reg_w_rd;
    a.wval = reg_w_val;
    return a;
  endfunction

  task automatic check(input string nm, input int k, input out_t e);
    out_t a;
    a = act();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, k, a, e);
    end
  endtask

  // Reference extension from the width rules using plain arithmetic.
  function automatic logic [31:0] ref_ext(input logic [2:0] f3,
                                          input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = w % 256;
    h = w % 65536;
    case (f3)
      3'd0: return (b > 127) ? b - 32'd256 : b;
      3'd1: return (h > 32767) ? h - 32'd65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic bit is_legal(input logic [2:0] f3);
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  // Expected outputs in cycle k after accept, from the load timeline.
  function automatic out_t exp_at(input int k, input logic [31:0] ea,
                                  input logic [2:0] f3,
                                  input logic [4:0] rd,
                                  input logic [31:0] ev,
                                  input int g, input int v,
                                  input int f);
    out_t e;
    bit killed;
    bit abort;
    int req_end;
    e = '0;
    if (!is_legal(f3)) begin
      if (k == 1) begin
        e.busy = 1'b1;
        e.done = 1'b1;
        e.exc  = 1'b1;
      end
      return e;
    end
    killed  = (f >= 1) && (f <= 2 + g + v);
    abort   = killed && (f < 1 + g);
    req_end = abort ? f : 1 + g;
    if (k >= 1 && k <= req_end) begin
      e.req  = 1'b1;
      e.addr = ea;
      e.busy = 1'b1;
    end
    if (!abort && k >= 2 + g && k <= 2 + g + v) e.busy = 1'b1;
    if (!killed && k == 3 + g + v) begin
      e.busy = 1'b1;
      e.done = 1'b1;
      if (rd != 5'd0) begin
        e.wop  = 1'b1;
        e.wrd  = rd;
        e.wval = ev;
      end
    end
    return e;
  endfunction

  task automatic idle_inputs();
    op                = 1'b0;
    ins_dec_op        = '0;
    ins_dec_funct3    = '0;
    ins_dec_rd        = '0;
    reg_rs1_val       = '0;
    imm_ext_ext       = '0;
    flush             = 1'b0;
    mif.mem_r_gnt     = 1'b0;
    mif.mem_r_valid   = 1'b0;
    mif.mem_r_val     = '0;
  endtask

  task automatic run_load(input vec_t t, input string nm);
    bit legal;
    bit killed;
    bit abort;
    int last;
    legal  = is_legal(t.f3);
    killed = legal && t.f >= 1 && t.f <= 2 + t.g + t.v;
    abort  = killed && t.f < 1 + t.g;
    if (!legal)      last = 2;
    else if (abort)  last = t.f + 1;
    else if (killed) last = 3 + t.g + t.v;
    else             last = 4 + t.g + t.v;
    @(posedge clk); #1;
    idle_inputs();
    op             = 1'b1;
    ins_dec_op     = OPC_LOAD;
    ins_dec_funct3 = t.f3;
    ins_dec_rd     = t.rd;
    reg_rs1_val    = t.rs1;
    imm_ext_ext    = t.imm;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      op             = (k < last) ? 1'($urandom) : 1'b0;
      ins_dec_op     = ($urandom % 2) ? OPC_LOAD : 7'($urandom);
      ins_dec_funct3 = 3'($urandom);
      ins_dec_rd     = 5'($urandom);
      reg_rs1_val    = $urandom;
      imm_ext_ext    = $urandom;
      flush          = legal && (k == t.f);
      mif.mem_r_gnt  = legal && !abort && (k == 1 + t.g);
      mif.mem_r_valid = legal && !abort && (k == 2 + t.g + t.v);
      mif.mem_r_val  = mif.mem_r_valid ? t.word : $urandom;
      @(negedge clk);
      check(nm, k, exp_at(k, t.ea, t.f3, t.rd, t.ev, t.g, t.v, t.f));
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t r;
    tbl[0]  = '{32'h1000, 32'd4, 3'd0, 5'd5, 32'h000000F0,
                0, 0, -1, 32'h1004, 32'hFFFFFFF0};
    tbl[1]  = '{32'h2000, 32'hFFFFFFFE, 3'd5, 5'd7, 32'h1234ABCD,
                2, 3, -1, 32'h1FFE, 32'h0000ABCD};
    tbl[2]  = '{32'hFFFFFFFC, 32'd8, 3'd2, 5'd0, 32'hDEADBEEF,
                0, 1, -1, 32'h4, 32'hDEADBEEF};
    tbl[3]  = '{32'h40, 32'd0, 3'd3, 5'd9, 32'h0, 0, 0, -1, 32'h0, 32'h0};
    tbl[4]  = '{32'h40, 32'd0, 3'd6, 5'd9, 32'h0, 0, 0, -1, 32'h0, 32'h0};
    tbl[5]  = '{32'h40, 32'd0, 3'd7, 5'd9, 32'h0, 0, 0, -1, 32'h0, 32'h0};
    tbl[6]  = '{32'h300, 32'd1, 3'd1, 5'd1, 32'h00008001,
                1, 0, -1, 32'h301, 32'hFFFF8001};
    tbl[7]  = '{32'h10, 32'd3, 3'd4, 5'd31, 32'h000000F0,
                0, 2, -1, 32'h13, 32'h000000F0};
    tbl[8]  = '{32'h80, 32'h10, 3'd1, 5'd2, 32'h12347FFF,
                0, 0, -1, 32'h90, 32'h00007FFF};
    tbl[9]  = '{32'h500, 32'd0, 3'd2, 5'd4, 32'h11111111,
                3, 0, 2, 32'h500, 32'h11111111};
    tbl[10] = '{32'h600, 32'd4, 3'd2, 5'd4, 32'h22222222,
                1, 2, 4, 32'h604, 32'h22222222};
    tbl[11] = '{32'h700, 32'd8, 3'd0, 5'd6, 32'h33333333,
                2, 1, 3, 32'h708, 32'h00000033};
    tbl[12] = '{32'h800, 32'd0, 3'd0, 5'd8, 32'hABCD127F,
                0, 0, -1, 32'h800, 32'h0000007F};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 0, '0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_load(tbl[i], $sformatf("vec%0d", i));

    // Reset during WAIT, then a late response arrives.
    @(posedge clk); #1;
    op = 1'b1; ins_dec_op = OPC_LOAD; ins_dec_funct3 = 3'd2;
    ins_dec_rd = 5'd3; reg_rs1_val = 32'h100; imm_ext_ext = 32'h0;
    @(posedge clk); #1;
    op = 1'b0; mif.mem_r_gnt = 1'b1;
    @(posedge clk); #1;
    mif.mem_r_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async", 2, '0);
    @(posedge clk); #1;
    mif.mem_r_valid = 1'b1; mif.mem_r_val = 32'h55AA55AA;
    @(negedge clk);
    check("rst_hold", 3, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_late_valid", 4, '0);
    @(posedge clk); #1;
    mif.mem_r_valid = 1'b0;
    @(negedge clk);
    check("rst_after", 5, '0);
    run_load('{32'h900, 32'd2, 3'd5, 5'd10, 32'h0000FEDC,
               0, 0, -1, 32'h902, 32'h0000FEDC}, "post_rst");

    for (int n = 0; n < 60; n++) begin
      r.rs1  = $urandom;
      r.imm  = $urandom;
      r.f3   = 3'($urandom);
      r.rd   = 5'($urandom);
      r.word = $urandom;
      r.g    = $urandom_range(0, 3);
      r.v    = $urandom_range(0, 3);
      r.f    = ($urandom % 4 == 0) ? $urandom_range(1, 2 + r.g + r.v) : -1;
      r.ea   = r.rs1 + r.imm;
      r.ev   = ref_ext(r.f3, r.word);
      run_load(r, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
